// File: rtl/sign_extend.sv
// Immediate extender for the MIPS datapath: 16-bit immediate to 32-bit operand,
// with a combinational path and a registered copy that feeds the ALU-B mux.
module sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  a,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic [OUT_W-1:0] y,
  output logic [OUT_W-1:0] y_comb,
  output logic             valid_o
);

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;
  localparam logic [1:0] MODE_BR   = 2'b11;

  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] zext_w;
  logic [OUT_W-1:0] lui_w;
  logic [OUT_W-1:0] br_w;
  logic [OUT_W-1:0] f_w;

  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;
  logic             valid_d;
  logic             valid_q;

  assign sext_w = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
  assign zext_w = {{(OUT_W-IN_W){1'b0}}, a};
  assign lui_w  = {a, {(OUT_W-IN_W){1'b0}}};
  // Branch offset is a word offset: shift the sign-extended value, dropping the top two bits.
  assign br_w   = {sext_w[OUT_W-3:0], 2'b00};

  always_comb begin
    f_w = sext_w;
    case (mode)
      MODE_SEXT: f_w = sext_w;
      MODE_ZEXT: f_w = zext_w;
      MODE_LUI:  f_w = lui_w;
      MODE_BR:   f_w = br_w;
      default:   f_w = sext_w;
    endcase
  end

  assign y_comb = f_w;

  // valid_o is sticky: it marks that y holds a loaded result and clears only on reset.
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    if (en) begin
      y_d     = f_w;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y       = y_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: driver pushes expected results, a negedge monitor
// pops and compares after every loading edge.
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [1:0]  mode;
  logic        en;
  logic [31:0] y;
  logic [31:0] y_comb;
  logic        valid_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic        en_at_edge = 1'b0;

  sign_extend #(.IN_W(16), .OUT_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .mode    (mode),
    .en      (en),
    .y       (y),
    .y_comb  (y_comb),
    .valid_o (valid_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // monitor: records whether a load edge happened, compares on the following negedge
  always @(posedge clk) en_at_edge = en && rst_n;

  always @(negedge clk) begin
    if (en_at_edge) begin
      en_at_edge = 1'b0;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL scoreboard: output %08h with empty expected queue", y);
      end else begin
        check("sb_y", y, exp_q.pop_front());
        check("sb_valid", {31'd0, valid_o}, 32'd1);
      end
    end
  end

  // driver: apply one vector between edges, check y_comb, push expected if loading
  task automatic drive(input logic [15:0] a_v, input logic [1:0] m_v,
                       input logic en_v, input logic [31:0] exp_v);
    @(negedge clk);
    a    = a_v;
    mode = m_v;
    en   = en_v;
    #1;
    check("y_comb", y_comb, exp_v);
    if (en_v) exp_q.push_back(exp_v);
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [1:0]  m;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{16'h0000, 2'b00, 32'h00000000};
    vecs[1]  = '{16'h0001, 2'b00, 32'h00000001};
    vecs[2]  = '{16'h0002, 2'b00, 32'h00000002};
    vecs[3]  = '{16'h8000, 2'b00, 32'hFFFF8000};
    vecs[4]  = '{16'hFFFF, 2'b00, 32'hFFFFFFFF};
    vecs[5]  = '{16'h7FFF, 2'b00, 32'h00007FFF};
    vecs[6]  = '{16'h8000, 2'b01, 32'h00008000};
    vecs[7]  = '{16'h1234, 2'b10, 32'h12340000};
    vecs[8]  = '{16'hFFFF, 2'b10, 32'hFFFF0000};
    vecs[9]  = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vecs[10] = '{16'h0001, 2'b11, 32'h00000004};
    vecs[11] = '{16'h8000, 2'b11, 32'hFFFE0000};

    rst_n = 1'b0;
    a     = 16'h1234;
    mode  = 2'b00;
    en    = 1'b1;
    #1;
    check("reset_y", y, 32'h0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_y", y, 32'h0);
    check("reset_hold_valid", {31'd0, valid_o}, 32'd0);

    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("release_y", y, 32'h0);
    check("release_valid", {31'd0, valid_o}, 32'd0);

    // back-to-back loads covering all modes
    for (int i = 0; i < 12; i++) drive(vecs[i].a, vecs[i].m, 1'b1, vecs[i].e);
    idle();

    // hold: one load, then three cycles with en low and a different input
    drive(16'h0001, 2'b00, 1'b1, 32'h00000001);
    for (int i = 0; i < 3; i++) begin
      drive(16'hFFFF, 2'b00, 1'b0, 32'hFFFFFFFF);
      @(posedge clk);
      #1;
      check("hold_y", y, 32'h00000001);
      check("hold_valid", {31'd0, valid_o}, 32'd1);
    end

    // asynchronous reset between edges
    drive(16'hFFFF, 2'b00, 1'b1, 32'hFFFFFFFF);
    idle();
    #2;
    check("pre_reset_y", y, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    check("async_reset_y", y, 32'h0);
    check("async_reset_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // post-reset reload
    drive(16'h8000, 2'b11, 1'b1, 32'hFFFE0000);
    idle();
    @(negedge clk);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected results never observed (required 0)", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
